// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and stall controller for the five-stage RV32I core.
//
// Covers the hazards forwarding cannot: load-use, taken-branch flushes,
// instruction-fetch waits and data-memory waits. Control outputs are
// combinational from the current inputs and state and feed the pipeline
// registers in the same cycle. Stall counters, the wait counter and the
// sticky timeout flag update on the rising clock edge.
//
// Parameters:
//   DMEM_TIMEOUT  DWAIT cycles after which mem_timeout sets
//   CNT_W         width of lu_stalls / mem_stalls
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ID_RS1/ID_RS2, ID_uses_rs*    sources of the instruction in ID
//   EX_MemRead, EX_RD             load flag / destination of the EX instruction
//   EX_br_taken                   EX redirects the PC
//   imem_resp                     fetch completes this cycle
//   dmem_req, dmem_resp           MEM access outstanding / completes this cycle
//   *_hold                        freeze a pipeline register (or the PC)
//   *_bubble                      load a NOP into a pipeline register
//   ifid_flush, idex_flush        squash wrong-path instructions
//   lu_stalls, mem_stalls         saturating event counters
//   mem_timeout                   sticky data-access timeout flag
module hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RD,
    input  logic             EX_br_taken,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_bubble,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] lu_stalls,
    output logic [CNT_W-1:0] mem_stalls,
    output logic             mem_timeout
);

    // Wait counter is at least 8 bits and wide enough to hold DMEM_TIMEOUT.
    localparam int WCNT_W = ($clog2(DMEM_TIMEOUT + 1) > 8) ? $clog2(DMEM_TIMEOUT + 1) : 8;
    localparam logic [WCNT_W-1:0] WCNT_TO  = WCNT_W'(DMEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {RUN, DWAIT, LUSTALL} state_t;

    state_t            state, state_nxt;
    logic              dfreeze, ifreeze, lu, lu_take;
    logic [WCNT_W-1:0] wcnt, wcnt_inc;

    assign dfreeze = dmem_req & ~dmem_resp;
    assign ifreeze = ~imem_resp;
    assign lu = EX_MemRead & (EX_RD != 5'd0) &
                ((ID_uses_rs1 & (ID_RS1 == EX_RD)) | (ID_uses_rs2 & (ID_RS2 == EX_RD)));

    // A load-use stall is only issued when nothing above it in priority is
    // active. Masking it in LUSTALL limits the penalty to a single bubble.
    assign lu_take = lu & ~dfreeze & ~EX_br_taken & (state != LUSTALL);

    assign wcnt_inc = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;

    // One next-state rule covers every transition: a freeze always lands in
    // DWAIT, and DWAIT is left as soon as the freeze drops (dmem_resp).
    always_comb begin
        state_nxt = RUN;
        if (dfreeze)      state_nxt = DWAIT;
        else if (lu_take) state_nxt = LUSTALL;
    end

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        ifid_bubble  = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        if (dfreeze) begin
            // A taken branch stays visible in the frozen EX stage, so its
            // flush simply fires in the first unfrozen cycle.
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (EX_br_taken) begin
            // PC must load the redirect target even during a fetch wait;
            // ifid_flush discards whatever the missing fetch would deliver.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_take) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end else if (ifreeze) begin
            pc_hold     = 1'b1;
            ifid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wcnt        <= '0;
            lu_stalls   <= '0;
            mem_stalls  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state != DWAIT && state_nxt == DWAIT)
                wcnt <= '0;
            else if (state == DWAIT)
                wcnt <= wcnt_inc;

            if (state == DWAIT && wcnt_inc >= WCNT_TO)
                mem_timeout <= 1'b1;

            if (lu_take && lu_stalls != CNT_MAX)
                lu_stalls <= lu_stalls + 1'b1;
            if (dfreeze && mem_stalls != CNT_MAX)
                mem_stalls <= mem_stalls + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. Forwarding resolves data hazards only when the producer's result already exists; this block handles everything forwarding cannot: load-use hazards, taken-branch flushes, instruction-fetch waits and data-memory waits. It emits per-stage hold/bubble/flush controls and keeps saturating stall counters plus a memory-timeout flag.

## Interface
- `DMEM_TIMEOUT`, 255: cycles in `DWAIT` after which `mem_timeout` sets.
- `CNT_W`, 16: width of each stall counter.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ID_RS1`, `ID_RS2` in 5 each: source registers of the instruction in ID.
- `ID_uses_rs1`, `ID_uses_rs2` in 1 each: ID instruction actually reads that source.
- `EX_MemRead` in 1: instruction in EX is a load.
- `EX_RD` in 5: destination of the instruction in EX.
- `EX_br_taken` in 1: branch/jump in EX redirects the PC.
- `imem_resp` in 1: instruction fetch completes this cycle.
- `dmem_req` in 1: MEM stage has a load/store outstanding.
- `dmem_resp` in 1: data access completes this cycle.
- `pc_hold`, `ifid_hold`, `idex_hold`, `exmem_hold` out 1 each: freeze that register.
- `ifid_bubble`, `idex_bubble`, `memwb_bubble` out 1 each: load a NOP into that register.
- `ifid_flush`, `idex_flush` out 1 each: squash wrong-path instructions.
- `lu_stalls`, `mem_stalls` out `CNT_W` each: saturating event counters.
- `mem_timeout` out 1: sticky; set when a data access exceeds `DMEM_TIMEOUT`.

## Operation
- Combinational terms:
  - `dfreeze = dmem_req & ~dmem_resp`
  - `ifreeze = ~imem_resp`
  - `lu = EX_MemRead & (EX_RD != 0) & ((ID_uses_rs1 & ID_RS1 == EX_RD) | (ID_uses_rs2 & ID_RS2 == EX_RD))`
- Priority, highest first:
  1. `dfreeze`: assert all four holds and `memwb_bubble`. Everything else is suppressed, including flushes.
  2. `EX_br_taken`: `ifid_flush = idex_flush = 1`. Load-use is suppressed. `pc_hold = 0`, so the redirect target is loaded even when `ifreeze` is set; `ifid_flush` covers the missing fetch.
  3. `lu`: `pc_hold = ifid_hold = idex_bubble = 1` for exactly one cycle.
  4. `ifreeze`: `pc_hold = ifid_bubble = 1`.
  5. Otherwise: all outputs 0.
- A taken branch held by `dfreeze` keeps `EX_br_taken` asserted, because EX is frozen. The flush therefore fires in the first unfrozen cycle; no separate pending register is needed.
- FSM (`RUN`, `DWAIT`, `LUSTALL`), registered:
  - `RUN → DWAIT` when `dfreeze`.
  - `DWAIT → RUN` on `dmem_resp`.
  - `RUN → LUSTALL` when `lu` is taken (priority 3 wins).
  - `LUSTALL → RUN` unconditionally next cycle, or `→ DWAIT` if `dfreeze`.
  - In `LUSTALL`, `lu` is masked. This guarantees a single bubble even if EX fields glitch.
- Wait counter `wcnt` (8 bits minimum, sized for `DMEM_TIMEOUT`):
  - Cleared on entry to `DWAIT`; increments each `DWAIT` cycle; saturates.
  - When it reaches `DMEM_TIMEOUT`, set `mem_timeout`. It stays set until `rst`.
- Stall counters:
  - `lu_stalls` increments on each cycle a load-use bubble is issued.
  - `mem_stalls` increments on each cycle `dfreeze` is high.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the current inputs and state; they are used in the same cycle by the pipeline registers.
- State, `wcnt`, the counters and `mem_timeout` update on the rising `clk` edge.
- Reset: state `RUN`, `wcnt = 0`, `lu_stalls = mem_stalls = 0`, `mem_timeout = 0`. With `imem_resp = 1` and `dmem_req = 0`, all control outputs are 0.
- `rst` mid-`DWAIT`: the next state is `RUN` and the counters clear, regardless of `dmem_resp`.
- Load-use penalty: exactly 1 cycle. A load followed by a dependent instruction results in one `idex_bubble` cycle, then forwarding supplies the data.
- `dmem_resp` together with `dmem_req` in the same cycle: zero-wait access, no freeze, no counter increment.
- Simultaneous `lu` and `dfreeze`: freeze only. `lu` is re-evaluated after the freeze releases and, if still true, stalls then.

## Test plan
- Load-use: `EX_MemRead=1`, `EX_RD=5`, `ID_RS2=5`, `ID_uses_rs2=1`, memory ready.
  - Expect `pc_hold`, `ifid_hold` and `idex_bubble` high for exactly one cycle, and `lu_stalls` 0→1.
  - With `EX_RD=0` instead: no stall.
- Branch versus load-use: `EX_br_taken=1` with an `lu` condition present.
  - Expect `ifid_flush = idex_flush = 1`, `idex_bubble = 0`, `pc_hold = 0`.
- Data wait: `dmem_req=1`, `dmem_resp` low for 3 cycles, then high.
  - Expect all holds plus `memwb_bubble` for 3 cycles, `mem_stalls = 3`, state back in `RUN`.
  - Branch asserted throughout: flush appears only in the 4th cycle.
- Timeout: `DMEM_TIMEOUT=4`, `dmem_resp` held low for 6 cycles.
  - Expect `mem_timeout` set once 4 `DWAIT` cycles have elapsed, and still set after `dmem_resp`.
  - Expect it to clear only on `rst`.
- Saturation and reset: `CNT_W=4`, 20 load-use events.
  - Expect `lu_stalls` to stick at 15.
  - `rst` asserted mid-`DWAIT`: next cycle all counters are 0 and state is `RUN`.
- Fetch wait: `imem_resp=0` for 2 cycles, no other hazards.
  - Expect `pc_hold = ifid_bubble = 1` for 2 cycles and no counter changes.
